// File: rtl/wb_arch_state_pkg.sv
// Shared register-file encodings for the write-back architectural state.
// Reset is active-low across the codebase: RST_ENABLE is the level that resets.
package wb_arch_state_pkg;
    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM_C  = 32;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
endpackage

// File: rtl/wb_hilo_llbit.sv
// HI/LO pair and LLbit committed at write-back; outputs are registered only,
// the memory stage forwards in-flight values itself.
module wb_hilo_llbit
    import wb_arch_state_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              whilo_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              llbit_we_i,
    input  logic              llbit_value_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              llbit_o
);
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              llbit_q, llbit_d;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        llbit_d = llbit_q;
        if (whilo_i == WRITE_ENABLE) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
        // An exception flush kills any reservation, even one being set now.
        if (flush_i) begin
            llbit_d = 1'b0;
        end else if (llbit_we_i == WRITE_ENABLE) begin
            llbit_d = llbit_value_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_q    <= '0;
            lo_q    <= '0;
            llbit_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            llbit_q <= llbit_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign llbit_o = llbit_q;
endmodule

// File: rtl/wb_arch_state.sv
// Write-back architectural state: GPR file with two bypassed read ports,
// plus the HI/LO/LLbit sub-block.
module wb_arch_state
    import wb_arch_state_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int REG_NUM = REG_NUM_C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_value,
    input  logic              flush,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              LLbit_o
);
    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];

    // Stored value is passed in so the function stays free of module state.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_l,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              wreg,
        input logic [ADDR_W-1:0] wd,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (rst_l == RST_ENABLE)                        return '0;
        if (re != READ_ENABLE)                          return '0;
        if (raddr == NOP_REG_ADDR)                      return '0;
        if (wreg == WRITE_ENABLE && wd == raddr)        return wdata;
        return stored;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (wb_wreg == WRITE_ENABLE && wb_wd != NOP_REG_ADDR) begin
            regs_d[wb_wd] = wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = read_port(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, regs_q[raddr1]);
    assign rdata2 = read_port(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, regs_q[raddr2]);

    wb_hilo_llbit #(
        .DATA_W(DATA_W)
    ) u_hilo_llbit (
        .clk          (clk),
        .rst          (rst),
        .whilo_i      (wb_whilo),
        .hi_i         (wb_hi),
        .lo_i         (wb_lo),
        .llbit_we_i   (wb_LLbit_we),
        .llbit_value_i(wb_LLbit_value),
        .flush_i      (flush),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .llbit_o      (LLbit_o)
    );
endmodule

// File: tb/tb_wb_arch_state.sv
// Self-checking bench for wb_arch_state: directed scenarios plus a randomized
// run against an abstract model of the architectural state.
module tb_wb_arch_state;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi, wb_lo;
    logic        wb_LLbit_we, wb_LLbit_value, flush;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2, hi_o, lo_o;
    logic        LLbit_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_hi, m_lo;
    logic        m_ll;

    wb_arch_state dut (
        .clk(clk), .rst(rst),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value), .flush(flush),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
    );

    always #5 clk = ~clk;

    // Architectural effect of the inputs presented at the coming edge.
    task automatic model_commit;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_hi = 32'h0; m_lo = 32'h0; m_ll = 1'b0;
        end else begin
            if (wb_wreg && wb_wd != 5'd0) m_regs[wb_wd] = wb_wdata;
            if (wb_whilo) begin m_hi = wb_hi; m_lo = wb_lo; end
            if (flush) m_ll = 1'b0;
            else if (wb_LLbit_we) m_ll = wb_LLbit_value;
        end
    endtask

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
        if (!rst || !re || a == 5'd0) return 32'h0;
        if (wb_wreg && wb_wd == a) return wb_wdata;
        return m_regs[a];
    endfunction

    task automatic tick;
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wb_wreg = 0; wb_wd = 0; wb_wdata = 0; wb_whilo = 0; wb_hi = 0; wb_lo = 0;
        wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0; re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
    endtask

    task automatic test_reset;
        rst = 0; wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hDEADBEEF; re1 = 1; raddr1 = 5;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL rst_forced_read got=%h exp=0", rdata1); end
        tick(); tick();
        rst = 1; wb_wreg = 0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL rst_gpr5 got=%h exp=0", rdata1); end
        checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin failures++; $display("FAIL rst_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
        checks++; if (LLbit_o !== 1'b0) begin failures++; $display("FAIL rst_llbit got=%b exp=0", LLbit_o); end
    endtask

    task automatic test_write_read;
        idle_inputs();
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h12345678;
        tick();
        wb_wreg = 0; re1 = 1; raddr1 = 7;
        #1;
        checks++; if (rdata1 !== 32'h12345678) begin failures++; $display("FAIL wr_rd_7 got=%h exp=12345678", rdata1); end
        wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFFFFFF; raddr1 = 0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL zero_bypass got=%h exp=0", rdata1); end
        tick();
        wb_wreg = 0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL zero_read got=%h exp=0", rdata1); end
    endtask

    task automatic test_bypass;
        idle_inputs();
        wb_wreg = 1; wb_wd = 9; wb_wdata = 32'hA5A5A5A5; raddr1 = 9; raddr2 = 9; re1 = 1; re2 = 0;
        #1;
        checks++; if (rdata1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL bypass_p1 got=%h exp=a5a5a5a5", rdata1); end
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL bypass_p2_disabled got=%h exp=0", rdata2); end
        re2 = 1;
        #1;
        checks++; if (rdata2 !== 32'hA5A5A5A5) begin failures++; $display("FAIL bypass_p2 got=%h exp=a5a5a5a5", rdata2); end
        tick();
        wb_wreg = 0;
        #1;
        checks++; if (rdata1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL bypass_after got=%h exp=a5a5a5a5", rdata1); end
    endtask

    task automatic test_hilo;
        idle_inputs();
        wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
        #1;
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL hilo_no_bypass got=%h exp=0", hi_o); end
        tick();
        checks++; if (hi_o !== 32'h1 || lo_o !== 32'h2) begin failures++; $display("FAIL hilo_write got=%h/%h exp=1/2", hi_o, lo_o); end
        wb_whilo = 0; wb_hi = 32'h33; wb_lo = 32'h44;
        tick();
        checks++; if (hi_o !== 32'h1 || lo_o !== 32'h2) begin failures++; $display("FAIL hilo_hold got=%h/%h exp=1/2", hi_o, lo_o); end
    endtask

    task automatic test_llbit;
        idle_inputs();
        wb_LLbit_we = 1; wb_LLbit_value = 1;
        tick();
        checks++; if (LLbit_o !== 1'b1) begin failures++; $display("FAIL ll_set got=%b exp=1", LLbit_o); end
        // Flush beats the LLbit write but must not block a GPR write.
        flush = 1; wb_wreg = 1; wb_wd = 4; wb_wdata = 32'hCAFE0004;
        tick();
        checks++; if (LLbit_o !== 1'b0) begin failures++; $display("FAIL ll_flush got=%b exp=0", LLbit_o); end
        flush = 0; wb_LLbit_we = 0; wb_wreg = 0; re1 = 1; raddr1 = 4;
        tick();
        checks++; if (LLbit_o !== 1'b0) begin failures++; $display("FAIL ll_hold got=%b exp=0", LLbit_o); end
        checks++; if (rdata1 !== 32'hCAFE0004) begin failures++; $display("FAIL flush_gpr got=%h exp=cafe0004", rdata1); end
    endtask

    task automatic test_reset_mid;
        idle_inputs();
        wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h55; wb_whilo = 1; wb_hi = 32'h77; wb_lo = 32'h0;
        tick();
        wb_wreg = 0; wb_whilo = 0; re1 = 1; raddr1 = 3;
        #1;
        checks++; if (rdata1 !== 32'h55 || hi_o !== 32'h77) begin failures++; $display("FAIL mid_setup got=%h/%h exp=55/77", rdata1, hi_o); end
        rst = 0; wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h99; wb_whilo = 1; wb_hi = 32'h88;
        tick();
        rst = 1; wb_wreg = 0; wb_whilo = 0;
        #1;
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL mid_rst_gpr got=%h exp=0", rdata1); end
        checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL mid_rst_hi got=%h exp=0", hi_o); end
    endtask

    task automatic test_random;
        logic [31:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 29) != 0);
            wb_wreg        = $urandom_range(0, 1);
            wb_wd          = 5'($urandom_range(0, 31));
            wb_wdata       = $urandom;
            wb_whilo       = ($urandom_range(0, 3) == 0);
            wb_hi          = $urandom;
            wb_lo          = $urandom;
            wb_LLbit_we    = $urandom_range(0, 1);
            wb_LLbit_value = $urandom_range(0, 1);
            flush          = ($urandom_range(0, 5) == 0);
            re1            = ($urandom_range(0, 7) != 0);
            re2            = ($urandom_range(0, 7) != 0);
            raddr1         = ($urandom_range(0, 3) == 0) ? wb_wd : 5'($urandom_range(0, 31));
            raddr2         = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_read(re1, raddr1);
            e2 = exp_read(re2, raddr2);
            checks++; if (rdata1 !== e1) begin failures++; $display("FAIL rand_rd1 n=%0d got=%h exp=%h", n, rdata1, e1); end
            checks++; if (rdata2 !== e2) begin failures++; $display("FAIL rand_rd2 n=%0d got=%h exp=%h", n, rdata2, e2); end
            tick();
            checks++;
            if (hi_o !== m_hi || lo_o !== m_lo || LLbit_o !== m_ll) begin
                failures++;
                $display("FAIL rand_state n=%0d got=%h/%h/%b exp=%h/%h/%b", n, hi_o, lo_o, LLbit_o, m_hi, m_lo, m_ll);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_hi = 32'h0; m_lo = 32'h0; m_ll = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_hilo();
        test_llbit();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arch_state.md
Name: wb_arch_state

Overview:
- Write-back consumer of the MEM/WB pipeline register.
- Holds the architectural state that retiring instructions commit to: the 32-entry general register file, the HI/LO pair and the LLbit.
- Provides two bypassed GPR read ports to the decode stage.
- Provides registered HI/LO/LLbit to the memory stage, which forwards these against in-flight writes itself.

Parameters:
- DATA_W, 32, width of GPRs, HI, LO.
- ADDR_W, 5, GPR address width.
- REG_NUM, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- wb_wreg  in  1  GPR write enable from MEM/WB
- wb_wd  in  ADDR_W  GPR write address
- wb_wdata  in  DATA_W  GPR write data
- wb_whilo  in  1  HI/LO write enable
- wb_hi  in  DATA_W  HI write data
- wb_lo  in  DATA_W  LO write data
- wb_LLbit_we  in  1  LLbit write enable
- wb_LLbit_value  in  1  LLbit write value
- flush  in  1  exception flush; clears LLbit
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read address, port 1
- rdata1  out  DATA_W  read data, port 1 (combinational)
- re2  in  1  read enable, port 2
- raddr2  in  ADDR_W  read address, port 2
- rdata2  out  DATA_W  read data, port 2 (combinational)
- hi_o  out  DATA_W  current HI (registered)
- lo_o  out  DATA_W  current LO (registered)
- LLbit_o  out  1  current LLbit (registered)

Behaviour:

Reset (rst==0 at posedge):
- All GPRs, HI, LO and LLbit are cleared to 0.
- No write is performed that cycle, whatever the write enables say.
- While rst==0, rdata1/rdata2 are forced to 0 combinationally.
- hi_o/lo_o/LLbit_o read 0 from the first edge with rst low.
- Reset asserted mid-stream discards any write presented in the same cycle.

GPR write:
- At posedge, if rst==1, wb_wreg==1 and wb_wd!=0, then reg[wb_wd] <= wb_wdata.
- Writes to $0 are silently dropped; $0 always reads 0.

GPR read, evaluated independently per port, priority top-down:
- rst==0 -> 0.
- re==0 -> 0.
- raddr==0 -> 0.
- Bypass: wb_wreg==1 and wb_wd==raddr -> wb_wdata, so a same-cycle write is visible with zero latency.
- Otherwise -> reg[raddr].
- Both ports may read the same address at once.

HI/LO:
- At posedge, if rst==1 and wb_whilo==1, both HI and LO are written.
- They are always written as a pair; there is no partial write.
- hi_o/lo_o show the new value the cycle after the write edge; there is no internal bypass.

LLbit:
- At posedge, if rst==1 and flush==1, LLbit <= 0. Flush wins over a simultaneous wb_LLbit_we.
- Else if wb_LLbit_we==1, LLbit <= wb_LLbit_value.
- Else LLbit holds.
- LLbit_o is registered.

Ordering and simultaneity:
- flush does not block GPR or HI/LO writes. MEM/WB has already zeroed the enables of the flushed instruction.
- GPR, HI/LO and LLbit writes in the same cycle are all independent and all take effect.
- There is no stall input: MEM/WB turns a stall into a bubble with all enables 0, so state simply holds.

Decomposition:
- Shared define.v provides:
  - RegBus, RegAddrBus, ZeroWord, WriteEnable/WriteDisable, ReadEnable/ReadDisable, NOPRegAddr.
  - A new RstEnable value of 1'b0, with a codebase-wide audit of its users.
  - RegNum = 32.
- One natural sub-module, wb_hilo_llbit, holds the HI/LO and LLbit registers with the flush priority.
- The GPR array and its read bypass stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF; release; read raddr1=5, re1=1 -> rdata1=0; hi_o=lo_o=0; LLbit_o=0.
- Write then read: write 0x12345678 to $7; next cycle raddr1=7 -> 0x12345678. Write 0xFFFFFFFF to $0; read $0 -> 0.
- Bypass: same cycle wb_wreg=1, wb_wd=9, wb_wdata=0xA5A5A5A5, raddr1=raddr2=9, re1=1, re2=0 -> rdata1=0xA5A5A5A5 combinationally, rdata2=0. Next cycle (wb_wreg=0) rdata1 is still 0xA5A5A5A5.
- HI/LO: wb_whilo=1, wb_hi=0x1, wb_lo=0x2 -> same cycle hi_o unchanged; after edge hi_o=0x1, lo_o=0x2. wb_whilo=0 with other data -> values hold.
- LLbit: wb_LLbit_we=1, value=1 -> LLbit_o=1. Then flush=1 together with wb_LLbit_we=1, value=1 -> LLbit_o=0. Then flush=0, we=0 -> stays 0.
- Reset mid-operation: state $3=0x55, HI=0x77; assert rst=0 for one edge together with wb_wreg=1 to $3 -> $3 reads 0 and HI=0 afterwards; the write is discarded.
